// File: rtl/mine_field_gen.sv
// Minesweeper board generator: places mines pseudo-randomly on an 8x8 board
// (never on the safe cell), then computes each cell's neighbour-mine count.
module mine_field_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_BOMBS = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   bombs,
  input  logic [5:0]   safe_idx,
  output logic         busy,
  output logic         done,
  output logic [63:0]  mine_map,
  output logic [255:0] counts_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE,
    S_COUNT,
    S_DONE
  } state_t;

  if (SEED == 16'h0000) begin : g_bad_seed
    $error("mine_field_gen: SEED must be nonzero");
  end
  if (MAX_BOMBS > 63 || MAX_BOMBS < 0) begin : g_bad_max
    $error("mine_field_gen: MAX_BOMBS must be in 0..63");
  end

  state_t         r_state;
  logic [15:0]    r_lfsr;
  logic [5:0]     r_target;
  logic [5:0]     r_safe;
  logic [5:0]     r_placed;
  logic [5:0]     r_cell;
  logic           r_busy;
  logic           r_done;
  logic [63:0]    r_mine_map;
  logic [255:0]   r_counts;

  logic           w_fb;
  logic [5:0]     w_cand;
  logic [5:0]     w_target;
  logic [3:0]     w_cell_cnt;

  // Mines among the 8 neighbours of idx; off-board neighbours do not wrap.
  function automatic logic [3:0] f_nbr_count(input logic [63:0] map,
                                             input logic [5:0]  idx);
    logic [3:0]        cnt;
    logic signed [4:0] row;
    logic signed [4:0] col;
    cnt = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        row = $signed({2'b00, idx[5:3]}) + 5'(dr);
        col = $signed({2'b00, idx[2:0]}) + 5'(dc);
        if ((dr != 0 || dc != 0) &&
            row >= 5'sd0 && row <= 5'sd7 && col >= 5'sd0 && col <= 5'sd7)
          cnt = cnt + {3'b000, map[{row[2:0], col[2:0]}]};
      end
    end
    return cnt;
  endfunction

  assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cand     = r_lfsr[5:0];
  assign w_target   = (bombs > 8'(MAX_BOMBS)) ? 6'(MAX_BOMBS) : bombs[5:0];
  assign w_cell_cnt = f_nbr_count(r_mine_map, r_cell);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_target   <= 6'd0;
      r_safe     <= 6'd0;
      r_placed   <= 6'd0;
      r_cell     <= 6'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mine_map <= 64'd0;
      r_counts   <= 256'd0;
    end else begin
      // Free-running so the field depends on when start arrives.
      r_lfsr <= {r_lfsr[14:0], w_fb};
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_target <= w_target;
            r_safe   <= safe_idx;
            r_busy   <= 1'b1;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_mine_map <= 64'd0;
          r_counts   <= 256'd0;
          r_placed   <= 6'd0;
          r_state    <= S_PLACE;
        end
        S_PLACE: begin
          if (r_placed == r_target) begin
            r_cell  <= 6'd0;
            r_state <= S_COUNT;
          end else if (!r_mine_map[w_cand] && (w_cand != r_safe)) begin
            r_mine_map[w_cand] <= 1'b1;
            r_placed           <= r_placed + 6'd1;
          end
        end
        S_COUNT: begin
          r_counts[{r_cell, 2'b00} +: 4] <= w_cell_cnt;
          if (r_cell == 6'd63) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cell <= r_cell + 6'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign mine_map   = r_mine_map;
  assign counts_out = r_counts;

endmodule

// File: tb/tb_mine_field_gen.sv
// Directed bench for mine_field_gen: reset, zero/eight/full boards, ignored
// starts, mid-run reset and back-to-back runs, checked against a neighbour model.
module tb_mine_field_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   bombs = 8'd0;
  logic [5:0]   safe_idx = 6'd0;
  logic         busy;
  logic         done;
  logic [63:0]  mine_map;
  logic [255:0] counts_out;

  int n_total = 0;
  int n_fail  = 0;

  mine_field_gen #(.SEED(SEED), .MAX_BOMBS(63)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bombs     (bombs),
    .safe_idx  (safe_idx),
    .busy      (busy),
    .done      (done),
    .mine_map  (mine_map),
    .counts_out(counts_out)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_v(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: for every cell, scan all 64 cells for adjacent mines.
  function automatic logic [255:0] ref_counts(input logic [63:0] m);
    logic [255:0] res;
    int cnt, rn, cn, rk, ck;
    res = '0;
    for (int n = 0; n < 64; n++) begin
      cnt = 0;
      rn = n / 8;
      cn = n % 8;
      for (int k = 0; k < 64; k++) begin
        rk = k / 8;
        ck = k % 8;
        if (k != n && m[k] && rk - rn <= 1 && rn - rk <= 1 && ck - cn <= 1 && cn - ck <= 1)
          cnt++;
      end
      res[n*4 +: 4] = 4'(cnt);
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [7:0] b, input logic [5:0] s);
    bombs    = b;
    safe_idx = s;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Returns with cyc = cycle index (1 = CLEAR cycle) at which done was seen.
  task automatic wait_done(input int limit, output int cyc, output bit seen, output bit busy_ok);
    cyc = 1;
    busy_ok = busy;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    seen = done;
  endtask

  initial begin
    int          cyc;
    bit          seen;
    bit          bok;
    int          ndone;
    bit          busy_after;
    logic [63:0] map_a;

    tick();
    tick();
    chk_i("reset_busy", int'(busy), 0);
    chk_i("reset_done", int'(done), 0);
    chk_v("reset_map", 256'(mine_map), 256'd0);
    chk_v("reset_counts", counts_out, 256'd0);
    chk_v("reset_lfsr", 256'(dut.r_lfsr), 256'(SEED));
    rst = 1'b1;
    tick();
    tick();

    // zero mines
    run_start(8'd0, 6'd0);
    wait_done(200, cyc, seen, bok);
    chk_i("zero_done_seen", int'(seen), 1);
    chk_i("zero_latency", cyc, 67);
    chk_i("zero_busy_1_66", int'(bok), 1);
    chk_i("zero_busy_at_done", int'(busy), 0);
    chk_v("zero_map", 256'(mine_map), 256'd0);
    chk_v("zero_counts", counts_out, 256'd0);
    tick();
    chk_i("zero_done_single", int'(done), 0);

    // eight mines
    tick();
    run_start(8'd8, 6'd27);
    wait_done(5000, cyc, seen, bok);
    chk_i("eight_done_seen", int'(seen), 1);
    chk_i("eight_latency_min", int'(cyc >= 75), 1);
    chk_i("eight_popcount", $countones(mine_map), 8);
    chk_i("eight_safe_clear", int'(mine_map[27]), 0);
    chk_v("eight_counts", counts_out, ref_counts(mine_map));
    tick();
    chk_i("eight_done_single", int'(done), 0);

    // clamp to full board
    run_start(8'd200, 6'd0);
    wait_done(30000, cyc, seen, bok);
    chk_i("full_done_seen", int'(seen), 1);
    chk_v("full_map", 256'(mine_map), 256'(64'hFFFF_FFFF_FFFF_FFFE));
    chk_i("full_count0", int'(counts_out[3:0]), 3);
    chk_i("full_count9", int'(counts_out[39:36]), 7);
    chk_i("full_count63", int'(counts_out[255:252]), 3);
    chk_i("full_count7", int'(counts_out[31:28]), 3);
    chk_v("full_counts", counts_out, ref_counts(mine_map));
    tick();

    // start held high through PLACE and COUNT is ignored
    run_start(8'd8, 6'd10);
    bombs = 8'd40;
    tick();
    tick();
    start = 1'b1;
    cyc = 3;
    while (!done && cyc < 5000) begin
      tick();
      cyc++;
    end
    start = 1'b0;
    ndone = int'(done);
    chk_i("busy_start_done_seen", int'(done), 1);
    busy_after = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) ndone++;
      if (busy) busy_after = 1'b1;
    end
    chk_i("busy_start_popcount", $countones(mine_map), 8);
    chk_i("busy_start_safe", int'(mine_map[10]), 0);
    chk_i("busy_start_one_done", ndone, 1);
    chk_i("busy_start_no_requeue", int'(busy_after), 0);

    // reset in the middle of PLACE
    run_start(8'd20, 6'd33);
    repeat (9) tick();
    #2;
    rst = 1'b0;
    #1;
    chk_i("midrst_busy", int'(busy), 0);
    chk_i("midrst_done", int'(done), 0);
    chk_v("midrst_map", 256'(mine_map), 256'd0);
    chk_v("midrst_counts", counts_out, 256'd0);
    chk_v("midrst_lfsr", 256'(dut.r_lfsr), 256'(SEED));
    tick();
    rst = 1'b1;
    tick();
    run_start(8'd20, 6'd33);
    wait_done(5000, cyc, seen, bok);
    chk_i("postrst_done_seen", int'(seen), 1);
    chk_i("postrst_popcount", $countones(mine_map), 20);
    chk_i("postrst_safe", int'(mine_map[33]), 0);
    chk_v("postrst_counts", counts_out, ref_counts(mine_map));

    // back-to-back runs with different idle gaps
    repeat (3) tick();
    run_start(8'd10, 6'd5);
    wait_done(5000, cyc, seen, bok);
    chk_i("b2b_a_done_seen", int'(seen), 1);
    chk_i("b2b_a_popcount", $countones(mine_map), 10);
    chk_i("b2b_a_safe", int'(mine_map[5]), 0);
    chk_v("b2b_a_counts", counts_out, ref_counts(mine_map));
    map_a = mine_map;
    repeat (7) tick();
    chk_v("b2b_hold_map", 256'(mine_map), 256'(map_a));
    chk_v("b2b_hold_counts", counts_out, ref_counts(map_a));
    run_start(8'd10, 6'd40);
    wait_done(5000, cyc, seen, bok);
    chk_i("b2b_b_done_seen", int'(seen), 1);
    chk_i("b2b_b_popcount", $countones(mine_map), 10);
    chk_i("b2b_b_safe", int'(mine_map[40]), 0);
    chk_v("b2b_b_counts", counts_out, ref_counts(mine_map));
    chk_i("b2b_maps_differ", int'(mine_map != map_a), 1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

// File: doc/mine_field_gen.md
Name: mine_field_gen

Overview:
- Upstream board generator for the minesweeper game core.
- On a start pulse, it places a requested number of mines pseudo-randomly on the 8x8 board, never in a designated safe cell.
- It then computes the 4-bit neighbour-mine count of every cell.
- The game core loads mine_map and counts_out into its board state on the done pulse.

Parameters:
- SEED, 16'hACE1, LFSR reset value; must be nonzero (a zero value is a configuration error).
- MAX_BOMBS, 63, upper clamp on the requested mine count; must be ≤ 63 so the safe cell always fits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low; all state cleared while low.
- start  input  1  one-cycle request to generate a new field; honoured only in IDLE.
- bombs  input  8  requested mine count; sampled on the cycle start is accepted.
- safe_idx  input  6  cell that must stay mine-free; sampled with bombs.
- busy  output  1  high in CLEAR, PLACE and COUNT.
- done  output  1  one-cycle pulse when mine_map and counts_out are final.
- mine_map  output  64  bit n = 1 if cell n holds a mine.
- counts_out  output  256  counts_out[4n+3:4n] = number of mines among the 8 neighbours of cell n (0..8).

Behaviour:
- Cell indexing: n = row*8 + col, with row = n[5:3] and col = n[2:0]. This matches board[row][col] in the game core.
- Reset (rst low, async):
  - state = IDLE; busy = 0; done = 0.
  - mine_map = 0; counts_out = 0.
  - lfsr = SEED; internal counters = 0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every clock in every state, including IDLE, so field content depends on start timing.
  - Candidate cell = lfsr[5:0].
- State: IDLE
  - start=1 → CLEAR.
  - On that edge, latch target = min(bombs, MAX_BOMBS) and safe = safe_idx.
- State: CLEAR (1 cycle)
  - mine_map ← 0; counts_out ← 0; placed ← 0.
  - → PLACE.
- State: PLACE (one candidate per cycle)
  - If placed == target → COUNT, with cell index ← 0.
  - Else if mine_map[cand] == 0 and cand != safe: set the bit and placed ← placed + 1.
  - Else: reject the candidate and stay.
  - PLACE lasts at least target + 1 cycles.
  - Termination is guaranteed: the LFSR period of 65535 visits every 6-bit value.
- State: COUNT (exactly 64 cycles, one cell per cycle, ascending index)
  - counts_out[cell] ← popcount of valid neighbours.
  - Out-of-board neighbours (row or col outside 0..7) are excluded. No wrap-around at edges.
  - The cell's own mine bit is not counted.
  - After cell 63 → DONE.
- State: DONE (1 cycle)
  - done = 1; busy = 0.
  - → IDLE.
- Outputs hold their values from DONE until the CLEAR of the next accepted start.
- start while busy or in DONE: ignored, with no queuing.
- bombs / safe_idx changes after acceptance: no effect.
- Latency from the start-accepting edge to done high = 1 (CLEAR) + P (PLACE cycles) + 64 + 1 cycles.
  - For target = 0: P = 1, so done is high in the 67th cycle after acceptance.
- Reset mid-operation: immediate return to the reset values; a partially built map is discarded.
- bombs = 0: empty map, all counts 0, done still pulses.

Test Plan:
- Zero mines: rst low 2 cycles, release; start with bombs=0, safe_idx=0.
  → done exactly 67 cycles after acceptance; mine_map=0; counts_out=0; busy high for cycles 1..66.
- Eight mines: bombs=8, safe_idx=27.
  → popcount(mine_map)=8; mine_map[27]=0.
  → each counts_out nibble equals a reference-model neighbour count of mine_map.
  → done is a single cycle.
- Clamp / full board: bombs=200, safe_idx=0.
  → mine_map=64'hFFFF_FFFF_FFFF_FFFE.
  → count[0]=3, count[9]=7, count[63]=3, count[7]=3.
- Start while busy: assert start again during PLACE and during COUNT with bombs=40.
  → ignored; the first run completes with 8 mines (original target); exactly one done pulse.
- Reset mid-PLACE: bombs=20; drop rst 10 cycles after start.
  → on the same cycle (async): busy=0, mine_map=0, counts_out=0, lfsr=SEED.
  → after release, a new start produces a valid field.
- Back-to-back runs: two starts with bombs=10 and a different idle gap before each.
  → both fields have 10 mines with safe cell clear; mine_maps differ; outputs hold between done and the next CLEAR.
